// File: rtl/alu_pkg.sv
// alu_pkg: ALUctr codes, default width and flag bundle shared by the ALU decoder and execute stage
package alu_pkg;
  localparam int ALU_WIDTH = 32;
  typedef enum logic [2:0] {
    CTR_AND     = 3'b000,
    CTR_ADD     = 3'b001,
    CTR_OR      = 3'b010,
    CTR_BEQ_SUB = 3'b100,
    CTR_SUB     = 3'b101,
    CTR_SLT     = 3'b111
  } alu_ctr_e;
  typedef struct packed {
    logic zero;
    logic ovf;
    logic err;
  } alu_flags_t;
  function automatic logic ctr_undef(input logic [2:0] c);
    return c == 3'b011 || c == 3'b110;
  endfunction
endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: operation-in / result-out handshake bundle of the ALU execute stage
interface alu_exec_if import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_ctr;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_ovf;
  logic             out_err;
  modport master (
    output in_valid, in_ctr, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_ovf, out_err
  );
  modport slave (
    input  in_valid, in_ctr, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_ovf, out_err
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational ALU computing result, zero, signed overflow and undefined-code error
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       i_ctr,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_ovf,
  output logic             o_err
);
  logic [WIDTH-1:0] w_sum, w_dif;
  logic w_slt, w_sub, w_sa, w_sb;
  assign w_sum = i_a + i_b;
  assign w_dif = i_a - i_b;
  assign w_slt = $signed(i_a) < $signed(i_b);
  assign w_sub = i_ctr == CTR_SUB || i_ctr == CTR_BEQ_SUB;
  assign w_sa = i_a[WIDTH-1];
  assign w_sb = i_b[WIDTH-1];
  always_comb begin
    o_result = (i_ctr == CTR_AND) ? (i_a & i_b) :
               (i_ctr == CTR_ADD) ? w_sum :
               (i_ctr == CTR_OR)  ? (i_a | i_b) :
               w_sub              ? w_dif :
               (i_ctr == CTR_SLT) ? {{(WIDTH-1){1'b0}}, w_slt} : '0;
    o_ovf = (i_ctr == CTR_ADD) ? (w_sa == w_sb && w_sum[WIDTH-1] != w_sa) :
            w_sub              ? (w_sa != w_sb && w_dif[WIDTH-1] != w_sa) : 1'b0;
  end
  assign o_zero = o_result == '0;
  assign o_err = ctr_undef(i_ctr);
endmodule

// File: rtl/alu_exec.sv
// alu_exec: one-cycle ALU execute stage feeding a DEPTH-entry in-order result FIFO
module alu_exec import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  logic [WIDTH-1:0] r_res [DEPTH];
  alu_flags_t       r_flg [DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_res;
  logic             w_zero, w_ovf, w_err, w_push, w_pop, w_valid;
  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_ctr(bus.in_ctr), .i_a(bus.in_a), .i_b(bus.in_b),
    .o_result(w_res), .o_zero(w_zero), .o_ovf(w_ovf), .o_err(w_err)
  );
  assign w_valid = r_cnt != '0;
  assign bus.in_ready = rst_n && (r_cnt < C_FULL);
  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop = w_valid && bus.out_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_result = w_valid ? r_res[r_rp] : '0;
  assign bus.out_zero = w_valid && r_flg[r_rp].zero;
  assign bus.out_ovf = w_valid && r_flg[r_rp].ovf;
  assign bus.out_err = w_valid && r_flg[r_rp].err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == P_LAST) ? '0 : r_wp + 1'b1;
      if (w_pop) r_rp <= (r_rp == P_LAST) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_res[r_wp] <= w_res;
      r_flg[r_wp] <= '{zero: w_zero, ovf: w_ovf, err: w_err};
    end
  end
endmodule
